// File: rtl/bus_arbiter.sv
// bus_arbiter
// Round-robin arbiter and transfer sequencer for the shared 32-bit CPU bus.
// Requesters post a source select and a destination load mask. One owner at a
// time gets the bus for a SETTLE cycle and then a WRITE cycle. In WRITE the
// owner is acked and the destination load enables are pulsed.
//
// Ports:
//   clock        system clock, all state on rising edge
//   clear        synchronous active-high reset, overrides everything
//   req          per-requester request level
//   req_src      packed 5-bit source selects, requester i at [5i+4:5i]
//   req_dst      packed destination load masks, requester i at [DST_W*i +: DST_W]
//   req_lock     hold the grant for a back-to-back transfer
//   grant        one-hot current owner, zero when idle
//   ack          one-cycle pulse in the owner's WRITE cycle
//   bus_select   mux select code
//   bus_drive    source is driving the bus
//   dst_load     destination load enables (WRITE only, legal source only)
//   busy         high in SETTLE and WRITE
//   err_bad_src  one-cycle pulse when a transfer with an illegal source completes
module bus_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DST_W   = 24,
    parameter int SRC_MAX = 23
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [N_REQ-1:0]       req,
    input  logic [5*N_REQ-1:0]     req_src,
    input  logic [DST_W*N_REQ-1:0] req_dst,
    input  logic [N_REQ-1:0]       req_lock,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       ack,
    output logic [4:0]             bus_select,
    output logic                   bus_drive,
    output logic [DST_W-1:0]       dst_load,
    output logic                   busy,
    output logic                   err_bad_src
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [4:0]       SRC_MAX_C = 5'(SRC_MAX);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WRITE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   own_q, own_d;
    logic [4:0]         src_q, src_d;
    logic [DST_W-1:0]   dst_q, dst_d;

    // Outputs are registered; their next values are decoded from next state.
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [4:0]         sel_q, sel_d;
    logic               drive_q, drive_d;
    logic [DST_W-1:0]   load_q, load_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    logic               found_s;
    logic [IDX_W-1:0]   cand_s;

    // Next-state logic: round-robin pick in IDLE, lock continuation in WRITE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        src_d   = src_q;
        dst_d   = dst_q;
        found_s = 1'b0;
        cand_s  = '0;
        case (state_q)
            ST_IDLE: begin
                // Search ptr, ptr+1, ... modulo N_REQ; first set bit wins.
                for (int k = 0; k < N_REQ; k++) begin
                    cand_s = IDX_W'((int'(ptr_q) + k) % N_REQ);
                    if (!found_s && req[cand_s]) begin
                        found_s = 1'b1;
                        own_d   = cand_s;
                    end else begin
                        found_s = found_s;
                    end
                end
                if (found_s) begin
                    src_d   = req_src[5*int'(own_d) +: 5];
                    dst_d   = req_dst[DST_W*int'(own_d) +: DST_W];
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                if (req_lock[own_q] && req[own_q]) begin
                    // Back-to-back transfer for the same owner; ptr untouched.
                    src_d   = req_src[5*int'(own_q) +: 5];
                    dst_d   = req_dst[DST_W*int'(own_q) +: DST_W];
                    state_d = ST_SETTLE;
                end else begin
                    ptr_d   = (own_q == LAST_IDX) ? '0 : own_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode for the coming cycle, from next state and next latches.
    always_comb begin
        grant_d = '0;
        ack_d   = '0;
        sel_d   = 5'd0;
        drive_d = 1'b0;
        load_d  = '0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        if (state_d != ST_IDLE) begin
            grant_d[own_d] = 1'b1;
            sel_d          = src_d;
            drive_d        = 1'b1;
            busy_d         = 1'b1;
        end else begin
            busy_d = 1'b0;
        end
        if (state_d == ST_WRITE) begin
            ack_d[own_d] = 1'b1;
            if (src_d <= SRC_MAX_C) begin
                load_d = dst_d;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            err_d = 1'b0;
        end
    end

    // State, latches and registered outputs; clear wins over everything.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            src_q   <= 5'd0;
            dst_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            sel_q   <= 5'd0;
            drive_q <= 1'b0;
            load_q  <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            sel_q   <= sel_d;
            drive_q <= drive_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign bus_select  = sel_q;
    assign bus_drive   = drive_q;
    assign dst_load    = load_q;
    assign busy        = busy_q;
    assign err_bad_src = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Self-checking bench for bus_arbiter (N_REQ=4, DST_W=24, SRC_MAX=23).
// A transaction-level model predicts every acked transfer; a monitor compares
// each ack cycle against the predicted transfer. Directed sequences cover
// reset, single transfer, round-robin order, lock, illegal source and clear
// mid-transfer; a randomized phase follows.
module tb_bus_arbiter;

    logic        clock;
    logic        clear;
    logic [3:0]  req;
    logic [19:0] req_src;
    logic [95:0] req_dst;
    logic [3:0]  req_lock;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic [4:0]  bus_select;
    logic        bus_drive;
    logic [23:0] dst_load;
    logic        busy;
    logic        err_bad_src;

    bus_arbiter #(.N_REQ(4), .DST_W(24), .SRC_MAX(23)) dut (
        .clock       (clock),
        .clear       (clear),
        .req         (req),
        .req_src     (req_src),
        .req_dst     (req_dst),
        .req_lock    (req_lock),
        .grant       (grant),
        .ack         (ack),
        .bus_select  (bus_select),
        .bus_drive   (bus_drive),
        .dst_load    (dst_load),
        .busy        (busy),
        .err_bad_src (err_bad_src)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         idx;
        logic [4:0] src;
        logic [23:0] dst;
        int         cyc;
    } exp_t;

    typedef struct {
        int         idx;
        int         cyc;
        logic [4:0] sel;
        logic       err;
        logic [23:0] dst;
    } rec_t;

    exp_t exp_q[$];
    rec_t recs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Reference model: whole transfers, decided at the edges where the bus is free
    // or where the current owner's WRITE ends.
    initial begin : model
        int   owner;
        int   ptr;
        int   dec;
        int   e;
        int   w;
        exp_t x;
        owner = -1; ptr = 0; dec = 0;
        forever begin
            @(posedge clock);
            e = cyc;
            cyc++;
            if (clear) begin
                owner = -1;
                ptr   = 0;
                exp_q.delete();
            end else if (owner < 0) begin
                if (req != 4'b0) begin
                    w = -1;
                    for (int k = 0; k < 4; k++)
                        if (w < 0 && req[(ptr + k) % 4]) w = (ptr + k) % 4;
                    x.idx = w; x.src = req_src[5*w +: 5]; x.dst = req_dst[24*w +: 24]; x.cyc = e + 2;
                    exp_q.push_back(x);
                    owner = w;
                    dec   = e + 2;
                end
            end else if (e == dec) begin
                if (req_lock[owner] && req[owner]) begin
                    x.idx = owner; x.src = req_src[5*owner +: 5]; x.dst = req_dst[24*owner +: 24]; x.cyc = e + 2;
                    exp_q.push_back(x);
                    dec = e + 2;
                end else begin
                    ptr   = (owner + 1) % 4;
                    owner = -1;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every ack and checks the bus outputs.
    initial begin : monitor
        exp_t e;
        rec_t r;
        logic [3:0]  oh;
        logic [23:0] ld;
        forever begin
            @(negedge clock);
            if (ack != 4'b0) begin
                r.idx = -1;
                for (int i = 0; i < 4; i++) if (ack[i]) r.idx = i;
                r.cyc = cyc; r.sel = bus_select; r.err = err_bad_src; r.dst = dst_load;
                recs.push_back(r);
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    oh = 4'b0001 << e.idx;
                    ld = (e.src <= 5'd23) ? e.dst : 24'd0;
                    check("ack_cycle", 32'(cyc), 32'(e.cyc));
                    check("ack_onehot", 32'(ack), 32'(oh));
                    check("grant_at_ack", 32'(grant), 32'(oh));
                    check("bus_select_at_ack", 32'(bus_select), 32'(e.src));
                    check("dst_load_at_ack", 32'(dst_load), 32'(ld));
                    check("err_bad_src_at_ack", 32'(err_bad_src), 32'(e.src > 5'd23));
                    check("drive_busy_at_ack", 32'({bus_drive, busy}), 32'd3);
                end
            end else begin
                if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                    e = exp_q.pop_front();
                    check("missing_ack", 32'(ack), 32'(4'b0001 << e.idx));
                end
                check("load_without_ack", 32'(dst_load), 32'd0);
                check("err_without_ack", 32'(err_bad_src), 32'd0);
                if (grant == 4'b0)
                    check("idle_outputs", 32'({bus_select, bus_drive, busy}), 32'd0);
            end
        end
    end

    task automatic new_req(input int i);
        logic [23:0] d;
        case ($urandom_range(2))
            0:       d = 24'd0;
            1:       d = 24'd1 << $urandom_range(23);
            default: d = 24'($urandom);
        endcase
        req[i]              = 1'b1;
        req_src[5*i +: 5]   = ($urandom_range(7) == 0) ? 5'($urandom_range(31, 24)) : 5'($urandom_range(23));
        req_dst[24*i +: 24] = d;
        req_lock[i]         = ($urandom_range(3) == 0);
    endtask

    // One cycle of requester behaviour; mode 0 drops on ack, 1 random, 2 lock test.
    task automatic step(input int mode);
        @(negedge clock);
        #1;
        if (mode == 1) clear = ($urandom_range(299) == 0);
        for (int i = 0; i < 4; i++) begin
            if (ack[i]) begin
                if (mode == 2 && i == 1 && req_lock[1] && req_src[9:5] == 5'd16) begin
                    req_src[9:5]   = 5'd17;
                    req_dst[47:24] = 24'd1 << 17;
                end else if (mode == 1 && $urandom_range(3) == 0) begin
                    new_req(i);
                end else begin
                    req[i] = 1'b0; req_lock[i] = 1'b0;
                end
            end else if (mode == 1) begin
                if (!req[i] && $urandom_range(3) == 0) new_req(i);
                else if (req[i] && grant[i] && $urandom_range(9) == 0) req[i] = 1'b0;
            end
        end
    endtask

    task automatic wait_recs(input string name, input int n, input int max_cyc, input int mode);
        for (int t = 0; t < max_cyc && recs.size() < n; t++) step(mode);
        if (recs.size() < n) check({"timeout_", name}, 32'(recs.size()), 32'(n));
    endtask

    task automatic wait_grant(input string name, input int i);
        int t;
        t = 0;
        while (!grant[i] && t < 20) begin step(0); t++; end
        if (!grant[i]) check({"timeout_", name}, 32'(grant), 32'(4'b0001 << i));
    endtask

    initial begin : stimulus
        clear    = 1'b1;
        req      = 4'hF;
        req_lock = 4'h0;
        for (int i = 0; i < 4; i++) begin
            req_src[5*i +: 5]   = 5'(i + 1);
            req_dst[24*i +: 24] = 24'd1 << i;
        end

        // Reset with all requesters asserted.
        step(0); step(0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_bus", 32'({bus_select, bus_drive}), 32'd0);
        check("rst_dst_load", 32'(dst_load), 32'd0);
        check("rst_busy_err", 32'({busy, err_bad_src}), 32'd0);
        clear = 1'b0;

        // Round-robin 0,1,2,3 at 3-cycle spacing, then 0,2.
        recs.delete();
        wait_recs("rr4", 4, 40, 0);
        if (recs.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("rr4_order", 32'(recs[i].idx), 32'(i));
                check("rr4_spacing", 32'(recs[i].cyc - recs[0].cyc), 32'(3 * i));
            end
        req[0] = 1'b1; req[2] = 1'b1;
        recs.delete();
        wait_recs("rr2", 2, 20, 0);
        if (recs.size() >= 2) begin
            check("rr2_first", 32'(recs[0].idx), 32'd0);
            check("rr2_second", 32'(recs[1].idx), 32'd2);
        end

        // Single transfer: src 5, dst 0x010000.
        step(0);
        req[0] = 1'b1; req_src[4:0] = 5'd5; req_dst[23:0] = 24'h010000;
        step(0);
        check("single_settle_sel", 32'(bus_select), 32'd5);
        check("single_settle_drive", 32'({bus_drive, busy}), 32'd3);
        check("single_settle_grant", 32'(grant), 32'd1);
        check("single_settle_noload", 32'({ack, dst_load}), 32'd0);
        step(0);
        check("single_write_sel", 32'(bus_select), 32'd5);
        check("single_write_load", 32'(dst_load), 32'h010000);
        check("single_write_ack", 32'(ack), 32'd1);
        step(0);
        check("single_idle", 32'({grant, bus_drive, busy, ack}), 32'd0);

        // Lock: requester 1 twice (src 16 then 17) while 2 waits.
        req[1] = 1'b1; req_lock[1] = 1'b1; req_src[9:5] = 5'd16; req_dst[47:24] = 24'd1 << 16;
        req[2] = 1'b1; req_src[14:10] = 5'd7; req_dst[71:48] = 24'd1 << 7;
        recs.delete();
        wait_recs("lock", 3, 30, 2);
        if (recs.size() >= 3) begin
            check("lock_order0", 32'(recs[0].idx), 32'd1);
            check("lock_order1", 32'(recs[1].idx), 32'd1);
            check("lock_order2", 32'(recs[2].idx), 32'd2);
            check("lock_spacing", 32'(recs[1].cyc - recs[0].cyc), 32'd2);
            check("lock_second_src", 32'(recs[1].sel), 32'd17);
            check("unlock_spacing", 32'(recs[2].cyc - recs[1].cyc), 32'd3);
        end

        // Illegal source 25 on requester 3.
        step(0);
        req[3] = 1'b1; req_src[19:15] = 5'd25; req_dst[95:72] = 24'h000001;
        wait_grant("illegal", 3);
        check("illegal_settle_noload", 32'(dst_load), 32'd0);
        step(0);
        check("illegal_ack", 32'(ack), 32'h8);
        check("illegal_err", 32'(err_bad_src), 32'd1);
        check("illegal_noload", 32'(dst_load), 32'd0);

        // Clear during SETTLE of requester 2, then ptr must restart at 0.
        step(0);
        req[2] = 1'b1; req_src[14:10] = 5'd9; req_dst[71:48] = 24'd1 << 9;
        wait_grant("clear_mid", 2);
        clear = 1'b1;
        recs.delete();
        step(0);
        check("clear_outputs", 32'({grant, ack, bus_select, bus_drive, busy, err_bad_src}), 32'd0);
        check("clear_dst_load", 32'(dst_load), 32'd0);
        clear = 1'b0; req[2] = 1'b0;
        for (int t = 0; t < 4; t++) step(0);
        check("clear_no_ack", 32'(recs.size()), 32'd0);
        req[1] = 1'b1; req[3] = 1'b1;
        wait_recs("after_clear", 2, 20, 0);
        if (recs.size() >= 2) check("after_clear_first", 32'(recs[0].idx), 32'd1);

        // Randomized traffic.
        for (int t = 0; t < 3000; t++) step(1);
        clear = 1'b0; req = 4'h0; req_lock = 4'h0;
        for (int t = 0; t < 10; t++) step(0);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Round-robin arbiter and transfer sequencer for the shared 32-bit CPU bus and its 32-to-1 bus multiplexer. Up to N_REQ requesters (control unit, I/O port, DMA-style helpers) each post a source select plus a one-hot destination load mask. The arbiter grants one requester at a time, drives the mux select and the bus-drive strobe, then pulses the destination register load enables.
It sits between the requesters and the bus mux / register-file load lines.

Parameters:
N_REQ, 4, number of requesters (2..8)
DST_W, 24, width of the destination load-enable mask (one bit per bus-loadable register)
SRC_MAX, 23, highest legal mux select code; codes above are illegal

Ports:
clock  in  1  system clock, all state on rising edge
clear  in  1  synchronous, active-high reset
req  in  N_REQ  per-requester transfer request, level
req_src  in  5*N_REQ  packed source select; requester i uses bits [5i+4:5i]
req_dst  in  DST_W*N_REQ  packed one-hot destination load mask; requester i uses bits [DST_W*i+DST_W-1:DST_W*i]
req_lock  in  N_REQ  keep grant for a back-to-back transfer if still requesting
grant  out  N_REQ  one-hot current owner, zero when idle
ack  out  N_REQ  one-cycle pulse in the WRITE cycle of the owner's transfer
bus_select  out  5  mux select code
bus_drive  out  1  bus contents valid / source driving
dst_load  out  DST_W  destination load enables
busy  out  1  high in SETTLE and WRITE
err_bad_src  out  1  one-cycle pulse when a transfer with an illegal source completes

Behaviour:
- Reset:
  - clear=1 at a rising edge forces state=IDLE and round-robin pointer ptr=0.
  - grant, ack, bus_select, bus_drive, dst_load, busy and err_bad_src are all 0 in the cycle after that edge.
  - clear overrides every other input, including mid-transfer. An aborted transfer gets no ack and no dst_load.
- State machine, 3 states:
  - IDLE:
    - If no req bit is set, stay in IDLE.
    - Otherwise select the first set req bit searching ptr, ptr+1, … mod N_REQ.
    - Latch that index g, its req_src and its req_dst. Next state is SETTLE.
  - SETTLE:
    - grant[g]=1, bus_select=latched src, bus_drive=1, dst_load=0, busy=1.
    - Next state is always WRITE.
  - WRITE:
    - grant[g]=1, bus_select=latched src, bus_drive=1, busy=1, ack[g]=1.
    - dst_load=latched dst if src<=SRC_MAX. Otherwise dst_load=0 and err_bad_src=1.
    - If req_lock[g] and req[g] are both sampled high: re-latch req_src/req_dst of g, go to SETTLE, ptr unchanged.
    - Otherwise set ptr=(g+1) mod N_REQ and go to IDLE.
- Outputs:
  - All outputs are decoded from registered state/latches only; there are no combinational paths from req* to outputs.
  - In IDLE, bus_select=0 and bus_drive=0.
- Latency and throughput:
  - A request sampled at edge k (state IDLE) gives SETTLE in cycle k+1 and WRITE/ack in cycle k+2.
  - An unlocked transfer takes 3 cycles; a locked back-to-back transfer takes 2 cycles.
- Requester rules:
  - req_src/req_dst must stay stable from request until ack.
  - A requester drops req in the cycle after ack unless it wants another transfer.
  - Deasserting req while granted does not abort; the latched transfer completes and acks.
- Boundary cases:
  - req_dst=0 is legal: transfer runs and acks, nothing is loaded.
  - Multi-hot req_dst is passed through unchanged (broadcast load).
  - A lock held continuously starves others by design.
  - ptr wraps N_REQ-1→0.
  - Simultaneous requests are resolved only in IDLE; new requests arriving during SETTLE/WRITE wait.

Test Plan:
- Reset: clear=1 for 2 cycles with req=4'b1111 -> all outputs 0, state IDLE; first grant after release goes to requester 0.
- Single transfer: req[0]=1, src0=5, dst0=24'h010000 at edge k -> bus_select=5 and bus_drive=1 in k+1 and k+2; dst_load=24'h010000 and ack[0]=1 only in k+2; idle at k+3.
- Round-robin: req=4'b1111 held, each requester dropping after its ack -> grant order 0,1,2,3 at 3-cycle spacing. Then reassert req[0] and req[2] -> order 0,2.
- Lock: req[1] with lock, two transfers (src=16, then src=17) while req[2] pending -> WRITE cycles 2 apart for 1, then 1 unlocks and requester 2 is granted next.
- Illegal source: req[3] with src=25, dst=24'h000001 -> ack[3]=1, err_bad_src=1 in WRITE, dst_load=0 throughout.
- Clear mid-transfer: assert clear during SETTLE of requester 2 -> no ack/dst_load ever issued, outputs 0 next cycle, ptr=0.
